video_scale_cfg_ctrl: RTL and testbench
=======================================

VIDEO_SCALE_CFG_CTRL -- requirements
Module: video_scale_cfg_ctrl

Interface
REQ-001 Parameter SYNC_LEN, default 4, number of extra cycles frame_sync_n stays low after new coefficients are applied (range 1-255).
REQ-002 vout_clk  in  1  single clock for all logic.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 vs_in  in  1  source frame-start level; a 0->1 transition marks a frame boundary.
REQ-005 cfg_update  in  1  one-cycle request to apply the cfg_* values at the next frame boundary.
REQ-006 cfg_vin_xres, cfg_vin_yres, cfg_vout_xres, cfg_vout_yres  in  16 each  requested resolutions.
REQ-007 vin_xres, vin_yres, vout_xres, vout_yres  out  16 each  applied resolutions.
REQ-008 scaler_width, scaler_height  out  32 each  16.16 scale factors.
REQ-009 frame_sync_n  out  1  scaler frame reset, active low.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 cfg_done  out  1  one-cycle pulse when a new configuration is applied.
REQ-012 cfg_err  out  1  sticky divide-by-zero flag.

Function
REQ-013 The block SHALL register vs_in once (vs_d) and detect edge = vs_in & ~vs_d.
REQ-014 A pending flag SHALL be set by cfg_update in any state and cleared on the cycle the FSM leaves IDLE; if both happen in the same cycle, pending SHALL remain 1.
REQ-015 FSM states: IDLE, LATCH, DIV_W, DIV_H, SYNC.
REQ-016 IDLE -> LATCH when edge & pending; otherwise the FSM SHALL stay in IDLE.
REQ-017 LATCH (1 cycle) SHALL capture the four cfg_* inputs into shadow registers.
REQ-018 On leaving LATCH, the FSM SHALL go to IDLE if the shadow vout_xres or vout_yres is 0, and to DIV_W otherwise.
REQ-019 In the zero case, cfg_err SHALL be set and all outputs SHALL keep their previous values.
REQ-020 DIV_W SHALL compute floor({vin_xres,16'h0} / vout_xres) with a 32-bit restoring divider, one quotient bit per cycle, MSB first, in exactly 32 cycles.
REQ-021 DIV_H SHALL do the same for the y values in 32 cycles, reusing the same divider hardware.
REQ-022 Each quotient SHALL have 1 added, modulo 2^32, before being stored.
REQ-023 frame_sync_n SHALL be low during every cycle in DIV_W, DIV_H and SYNC, and high in all other states.
REQ-024 On entry to SYNC, the block SHALL update scaler_width, scaler_height and the four resolution outputs simultaneously.
REQ-025 SYNC SHALL last SYNC_LEN cycles, then go to IDLE.
REQ-026 On the SYNC->IDLE transition, cfg_done SHALL pulse for 1 cycle and cfg_err SHALL clear.
REQ-027 Outputs SHALL change only on SYNC entry, so they are stable whenever frame_sync_n is high.
REQ-028 vs_in edges outside IDLE SHALL be ignored.
REQ-029 cfg_update received while busy SHALL cause one further run at the next edge after the FSM returns to IDLE.
REQ-030 frame_sync_n low time SHALL equal 64+SYNC_LEN cycles.
REQ-031 Latency from the edge cycle to cfg_done SHALL be 1 (LATCH) + 64 + SYNC_LEN cycles.

Reset
REQ-032 While rst is asserted: FSM = IDLE, pending = 1, frame_sync_n = 1, busy = 0, cfg_done = 0, cfg_err = 0, all resolution and scaler outputs = 0, and the divider state is cleared.
REQ-033 Reset asserted mid-division SHALL abort the run with no partial output update.
REQ-034 After reset, the first vs_in edge SHALL apply the current cfg_* values with no cfg_update required.

Verification
REQ-035 Reset release, cfg = 1920x1080 -> 1280x720, one vs_in edge -> scaler_width = scaler_height = 0x00018001; frame_sync_n low for 68 cycles; cfg_done 69 cycles after the edge.
REQ-036 cfg = 1280x720 -> 1920x1080 with cfg_update -> both factors = 0x0000AAAB after the next edge; no run occurs on a vs_in edge without a preceding cfg_update.
REQ-037 cfg_vout_xres = 0 with cfg_update and an edge -> cfg_err = 1, frame_sync_n stays high, outputs unchanged, busy high for 1 cycle; a later valid config clears cfg_err.
REQ-038 cfg_update pulsed during DIV_H, with a vs_in edge also during DIV_H -> that edge is ignored; a second run starts at the first edge after returning to IDLE.
REQ-039 rst asserted at cycle 20 of DIV_W -> frame_sync_n = 1 immediately, outputs = 0, pending = 1; the next edge runs normally.
REQ-040 cfg_update and an edge in the same IDLE cycle -> the run starts and pending stays 1, so a second run occurs at the following edge.

Source files
------------

// File: rtl/video_scale_cfg_ctrl.sv
// Applies a scaler configuration at a frame boundary: 16.16 factors from a shared serial divider.
// Latency: edge to cfg_done = 65+SYNC_LEN cycles; no backpressure, vs_in edges while busy are dropped.
module video_scale_cfg_ctrl #(
    parameter int SYNC_LEN = 4
) (
    input  logic        vout_clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        cfg_update,
    input  logic [15:0] cfg_vin_xres,
    input  logic [15:0] cfg_vin_yres,
    input  logic [15:0] cfg_vout_xres,
    input  logic [15:0] cfg_vout_yres,
    output logic [15:0] vin_xres,
    output logic [15:0] vin_yres,
    output logic [15:0] vout_xres,
    output logic [15:0] vout_yres,
    output logic [31:0] scaler_width,
    output logic [31:0] scaler_height,
    output logic        frame_sync_n,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    typedef enum logic [2:0] {IDLE, LATCH, DIV_W, DIV_H, SYNC} state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic        vs_d;
    logic        vs_edge;
    logic        pending;
    logic [15:0] sh_vin_x;
    logic [15:0] sh_vin_y;
    logic [15:0] sh_vout_x;
    logic [15:0] sh_vout_y;
    logic [7:0]  cnt;
    logic [31:0] div_dvd;
    logic [31:0] div_quo;
    logic [31:0] quo_nxt;
    logic [31:0] w_fac;
    logic [15:0] div_dvs;
    logic [15:0] div_rem;
    logic [15:0] rem_diff;
    logic [15:0] rem_nxt;
    logic [16:0] rem_sh;
    logic        rem_ge;
    logic        div_last;
    logic        sync_last;
    logic        cfg_zero;

    assign vs_edge   = vs_in & ~vs_d;
    assign div_last  = (cnt == 8'd31);
    assign sync_last = (cnt == SYNC_LAST);
    assign cfg_zero  = (cfg_vout_xres == 16'h0) || (cfg_vout_yres == 16'h0);

    // Restoring step: the remainder stays below the divisor, so 16 bits hold it
    // and the low 16 bits of the difference are exact whenever it is taken.
    assign rem_sh   = {div_rem, div_dvd[31]};
    assign rem_ge   = (rem_sh >= {1'b0, div_dvs});
    assign rem_diff = rem_sh[15:0] - div_dvs;
    assign rem_nxt  = rem_ge ? rem_diff : rem_sh[15:0];
    assign quo_nxt  = {div_quo[30:0], rem_ge};

    always_ff @(posedge vout_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_edge && pending) state_nxt = LATCH;
            LATCH:   state_nxt = cfg_zero ? IDLE : DIV_W;
            DIV_W:   if (div_last) state_nxt = DIV_H;
            DIV_H:   if (div_last) state_nxt = SYNC;
            SYNC:    if (sync_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_sync_n = 1'b1;
        busy         = (state != IDLE);
        cfg_done     = 1'b0;
        case (state)
            DIV_W, DIV_H: frame_sync_n = 1'b0;
            SYNC: begin
                frame_sync_n = 1'b0;
                cfg_done     = sync_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge vout_clk or posedge rst) begin
        if (rst) begin
            vs_d          <= 1'b0;
            pending       <= 1'b1;
            sh_vin_x      <= '0;
            sh_vin_y      <= '0;
            sh_vout_x     <= '0;
            sh_vout_y     <= '0;
            cnt           <= '0;
            div_dvd       <= '0;
            div_dvs       <= '0;
            div_rem       <= '0;
            div_quo       <= '0;
            w_fac         <= '0;
            vin_xres      <= '0;
            vin_yres      <= '0;
            vout_xres     <= '0;
            vout_yres     <= '0;
            scaler_width  <= '0;
            scaler_height <= '0;
            cfg_err       <= 1'b0;
        end else begin
            vs_d <= vs_in;
            // A request in the same cycle as the FSM leaving IDLE wins.
            if (cfg_update) begin
                pending <= 1'b1;
            end else if (state == IDLE && state_nxt != IDLE) begin
                pending <= 1'b0;
            end

            case (state)
                LATCH: begin
                    sh_vin_x  <= cfg_vin_xres;
                    sh_vin_y  <= cfg_vin_yres;
                    sh_vout_x <= cfg_vout_xres;
                    sh_vout_y <= cfg_vout_yres;
                    if (cfg_zero) begin
                        cfg_err <= 1'b1;
                    end else begin
                        div_dvd <= {cfg_vin_xres, 16'h0};
                        div_dvs <= cfg_vout_xres;
                        div_rem <= '0;
                        div_quo <= '0;
                        cnt     <= '0;
                    end
                end
                DIV_W: begin
                    div_dvd <= {div_dvd[30:0], 1'b0};
                    div_rem <= rem_nxt;
                    div_quo <= quo_nxt;
                    cnt     <= cnt + 8'd1;
                    if (div_last) begin
                        w_fac   <= quo_nxt + 32'd1;
                        div_dvd <= {sh_vin_y, 16'h0};
                        div_dvs <= sh_vout_y;
                        div_rem <= '0;
                        div_quo <= '0;
                        cnt     <= '0;
                    end
                end
                DIV_H: begin
                    div_dvd <= {div_dvd[30:0], 1'b0};
                    div_rem <= rem_nxt;
                    div_quo <= quo_nxt;
                    cnt     <= cnt + 8'd1;
                    if (div_last) begin
                        scaler_width  <= w_fac;
                        scaler_height <= quo_nxt + 32'd1;
                        vin_xres      <= sh_vin_x;
                        vin_yres      <= sh_vin_y;
                        vout_xres     <= sh_vout_x;
                        vout_yres     <= sh_vout_y;
                        cnt           <= '0;
                    end
                end
                SYNC: begin
                    cnt <= cnt + 8'd1;
                    if (sync_last) cfg_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_scale_cfg_ctrl.sv
// Directed and randomized checks of video_scale_cfg_ctrl against an arithmetic reference model.
module tb_video_scale_cfg_ctrl;

    localparam int SL = 4;

    logic        vout_clk;
    logic        rst;
    logic        vs_in;
    logic        cfg_update;
    logic [15:0] cfg_vin_xres;
    logic [15:0] cfg_vin_yres;
    logic [15:0] cfg_vout_xres;
    logic [15:0] cfg_vout_yres;
    logic [15:0] vin_xres;
    logic [15:0] vin_yres;
    logic [15:0] vout_xres;
    logic [15:0] vout_yres;
    logic [31:0] scaler_width;
    logic [31:0] scaler_height;
    logic        frame_sync_n;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: applied outputs, sticky error, pending request.
    logic [127:0] m_out;
    logic         m_err;
    bit           m_pending;

    video_scale_cfg_ctrl #(.SYNC_LEN(SL)) dut (
        .vout_clk      (vout_clk),
        .rst           (rst),
        .vs_in         (vs_in),
        .cfg_update    (cfg_update),
        .cfg_vin_xres  (cfg_vin_xres),
        .cfg_vin_yres  (cfg_vin_yres),
        .cfg_vout_xres (cfg_vout_xres),
        .cfg_vout_yres (cfg_vout_yres),
        .vin_xres      (vin_xres),
        .vin_yres      (vin_yres),
        .vout_xres     (vout_xres),
        .vout_yres     (vout_yres),
        .scaler_width  (scaler_width),
        .scaler_height (scaler_height),
        .frame_sync_n  (frame_sync_n),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    initial begin
        vout_clk = 1'b0;
        forever #5 vout_clk = ~vout_clk;
    end

    function automatic logic [127:0] outs();
        return {scaler_width, scaler_height, vin_xres, vin_yres, vout_xres, vout_yres};
    endfunction

    function automatic logic [31:0] factor(input logic [15:0] vin, input logic [15:0] vout);
        longint unsigned num;
        longint unsigned q;
        num = longint'(vin) * 64'd65536;
        q   = num / longint'(vout);
        return 32'(q + 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vout_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] vx, input logic [15:0] vy,
                           input logic [15:0] ox, input logic [15:0] oy);
        cfg_vin_xres  = vx;
        cfg_vin_yres  = vy;
        cfg_vout_xres = ox;
        cfg_vout_yres = oy;
    endtask

    task automatic pulse_upd();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        m_pending  = 1'b1;
    endtask

    // Raise vs_in in cycle 0, optionally pulse cfg_update at cycle upd_k and a
    // second vs_in edge at cycle vs2_k, then compare observed timing and outputs.
    task automatic run_edge(input string tag, input int upd_k, input int vs2_k);
        int           len;
        bit           ran;
        bit           zero;
        bit           good;
        int           fs_low;
        int           busy_n;
        int           done_k;
        int           done_n;
        int           chg_hi;
        logic [127:0] prev;
        logic [127:0] cur;
        logic [127:0] snap65;
        logic [127:0] exp_out;
        logic         exp_err;
        len    = 66 + SL + 8;
        ran    = m_pending;
        zero   = ran && (cfg_vout_xres == 16'h0 || cfg_vout_yres == 16'h0);
        good   = ran && !zero;
        fs_low = 0;
        busy_n = 0;
        done_k = -1;
        done_n = 0;
        chg_hi = 0;
        exp_out = m_out;
        exp_err = m_err;
        if (good) begin
            exp_out = {factor(cfg_vin_xres, cfg_vout_xres), factor(cfg_vin_yres, cfg_vout_yres),
                       cfg_vin_xres, cfg_vin_yres, cfg_vout_xres, cfg_vout_yres};
            exp_err = 1'b0;
        end else if (zero) begin
            exp_err = 1'b1;
        end
        vs_in      = 1'b1;
        cfg_update = (upd_k == 0);
        prev   = outs();
        snap65 = prev;
        for (int k = 1; k <= len; k++) begin
            step();
            cur = outs();
            if (cur !== prev && frame_sync_n) chg_hi++;
            prev = cur;
            if (!frame_sync_n) fs_low++;
            if (busy) busy_n++;
            if (cfg_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == 65) snap65 = cur;
            vs_in      = (k == vs2_k);
            cfg_update = (k == upd_k);
        end
        vs_in      = 1'b0;
        cfg_update = 1'b0;

        chk({tag, " fs_low"}, 128'(fs_low), good ? 128'(64 + SL) : 128'd0);
        chk({tag, " done_k"}, 128'(done_k), good ? 128'(65 + SL) : 128'(-1));
        chk({tag, " done_n"}, 128'(done_n), good ? 128'd1 : 128'd0);
        chk({tag, " busy_n"}, 128'(busy_n), good ? 128'(65 + SL) : (zero ? 128'd1 : 128'd0));
        chk({tag, " pre_sync_outs"}, snap65, m_out);
        chk({tag, " outs"}, cur, exp_out);
        chk({tag, " cfg_err"}, 128'(cfg_err), 128'(exp_err));
        chk({tag, " stable_when_high"}, 128'(chg_hi), 128'd0);

        m_out     = exp_out;
        m_err     = exp_err;
        m_pending = (upd_k >= 0) ? 1'b1 : (ran ? 1'b0 : m_pending);
    endtask

    initial begin
        rst        = 1'b1;
        vs_in      = 1'b0;
        cfg_update = 1'b0;
        set_cfg(16'd1920, 16'd1080, 16'd1280, 16'd720);
        m_out     = '0;
        m_err     = 1'b0;
        m_pending = 1'b1;

        repeat (3) step();
        chk("rst frame_sync_n", 128'(frame_sync_n), 128'd1);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst cfg_done", 128'(cfg_done), 128'd0);
        chk("rst cfg_err", 128'(cfg_err), 128'd0);
        chk("rst outs", outs(), 128'd0);
        rst = 1'b0;
        repeat (2) step();

        // First edge after reset applies cfg without an update request.
        run_edge("first", -1, -1);
        chk("first w_const", 128'(scaler_width), 128'h00018001);
        chk("first h_const", 128'(scaler_height), 128'h00018001);

        // New cfg without cfg_update: the edge must not start a run.
        set_cfg(16'd1280, 16'd720, 16'd1920, 16'd1080);
        run_edge("no_upd", -1, -1);
        pulse_upd();
        run_edge("down", -1, -1);
        chk("down w_const", 128'(scaler_width), 128'h0000AAAB);
        chk("down h_const", 128'(scaler_height), 128'h0000AAAB);

        // Zero output width flags an error and leaves outputs alone.
        set_cfg(16'd800, 16'd600, 16'd0, 16'd480);
        pulse_upd();
        run_edge("zero", -1, -1);
        set_cfg(16'd640, 16'd480, 16'd1024, 16'd768);
        pulse_upd();
        run_edge("err_clear", -1, -1);

        // Update and edge both during DIV_H: edge ignored, one more run later.
        set_cfg(16'd3840, 16'd2160, 16'd1920, 16'd1080);
        pulse_upd();
        run_edge("busy_upd", 40, 50);
        set_cfg(16'd720, 16'd576, 16'd1280, 16'd720);
        run_edge("busy_upd second", -1, -1);

        // Update coincident with the starting edge keeps pending set.
        set_cfg(16'd1000, 16'd333, 16'd7, 16'd3);
        pulse_upd();
        run_edge("same_cycle", 0, -1);
        set_cfg(16'd65535, 16'd1, 16'd1, 16'd65535);
        run_edge("same_cycle second", -1, -1);

        // Reset in the middle of DIV_W aborts the run.
        set_cfg(16'd1920, 16'd1200, 16'd1366, 16'd768);
        pulse_upd();
        vs_in = 1'b1;
        step();
        vs_in = 1'b0;
        repeat (21) step();
        chk("rst_mid pre frame_sync_n", 128'(frame_sync_n), 128'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid frame_sync_n", 128'(frame_sync_n), 128'd1);
        chk("rst_mid busy", 128'(busy), 128'd0);
        chk("rst_mid cfg_done", 128'(cfg_done), 128'd0);
        chk("rst_mid outs", outs(), 128'd0);
        step();
        rst = 1'b0;
        m_out     = '0;
        m_err     = 1'b0;
        m_pending = 1'b1;
        step();
        run_edge("after_rst", -1, -1);

        for (int i = 0; i < 8; i++) begin
            set_cfg(16'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)),
                    16'($urandom_range(1, 65535)));
            if ($urandom_range(0, 3) != 0) pulse_upd();
            run_edge($sformatf("rnd%0d", i), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
